// File: rtl/jump_pkg.sv
// Shared state encodings, default physics constants and helpers for the player
// vertical-motion engine.
package jump_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_FALL = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  localparam int SCREEN_H_DEF    = 480;
  localparam int PLYR_H_DEF      = 20;
  localparam int START_Y_DEF     = 400;
  localparam int SCROLL_LINE_DEF = 160;
  localparam int JUMP_SPD_DEF    = 12;
  localparam int MAX_FALL_DEF    = 10;
  localparam int GRAV_DIV_DEF    = 3;

  // Speed/position bundle for one physics step.
  typedef struct packed {
    logic [1:0] st;
    logic [9:0] y;
    logic [3:0] spd;
  } phys_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [9:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/gravity_divider.sv
// Modulo-DIV frame-tick counter with synchronous clear; o_wrap marks the tick
// on which the counter rolls over to zero.
module gravity_divider #(
  parameter int DIV = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_cnt <= '0;
    else if (i_clr)   r_cnt <= '0;
    else if (i_en)    r_cnt <= o_wrap ? '0 : r_cnt + CW'(1);
  end

endmodule

// File: rtl/player_jump_ctrl.sv
// Player vertical physics: gravity, platform bounce, scroll-line clamp, death.
// Optional macro SCROLL_SCORE_EN builds a saturating score accumulator of scroll.
module player_jump_ctrl
  import jump_pkg::*;
#(
  parameter int SCREEN_H    = SCREEN_H_DEF,
  parameter int PLYR_H      = PLYR_H_DEF,
  parameter int START_Y     = START_Y_DEF,
  parameter int SCROLL_LINE = SCROLL_LINE_DEF,
  parameter int JUMP_SPD    = JUMP_SPD_DEF,
  parameter int MAX_FALL    = MAX_FALL_DEF,
  parameter int GRAV_DIV    = GRAV_DIV_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame_tick,
  input  logic        i_start,
  input  logic        i_hit,
  input  logic [9:0]  i_floor,
  output logic [9:0]  o_plyr_y,
  output logic [3:0]  o_spd_y,
  output logic [1:0]  o_state,
  output logic        o_fly,
  output logic [9:0]  o_scroll_amt,
  output logic        o_bounce,
  output logic [15:0] o_score
);

  localparam logic [9:0]         LP_START    = 10'(START_Y);
  localparam logic [9:0]         LP_SCROLL   = 10'(SCROLL_LINE);
  localparam logic signed [10:0] LP_SCROLL_S = 11'(SCROLL_LINE);
  localparam logic [9:0]         LP_PLYR_H   = 10'(PLYR_H);
  localparam logic [9:0]         LP_DEAD_Y   = 10'(SCREEN_H - PLYR_H);
  localparam logic [11:0]        LP_PLYR_H12 = 12'(PLYR_H);
  localparam logic [11:0]        LP_SCR_H12  = 12'(SCREEN_H);
  localparam logic [3:0]         LP_JUMP     = 4'(JUMP_SPD);
  localparam logic [3:0]         LP_MAXF     = 4'(MAX_FALL);

  phys_t      r_cur;
  phys_t      w_nxt;
  logic       r_fly;
  logic [9:0] r_scroll;
  logic       r_bounce;
  logic       r_pend;

  logic [9:0]         w_scroll;
  logic               w_bounce;
  logic               w_wrap;
  logic               w_rest;
  logic               w_start_ok;
  logic               w_grav_en;
  logic               w_grav_clr;
  logic signed [10:0] w_ny_rise;
  logic signed [10:0] w_scr_diff;
  logic [10:0]        w_ny_fall;
  logic               w_dead;
  logic [9:0]         w_bounce_y;

  // A start seen between frame ticks is remembered until the next tick.
  assign w_rest     = (r_cur.st == ST_IDLE) || (r_cur.st == ST_DEAD);
  assign w_start_ok = i_frame_tick && w_rest && (i_start || r_pend);
  assign w_grav_en  = i_frame_tick && !w_rest;
  assign w_grav_clr = w_start_ok || w_bounce;

  assign w_ny_rise  = $signed({1'b0, r_cur.y}) - $signed({7'b0, r_cur.spd});
  assign w_scr_diff = LP_SCROLL_S - w_ny_rise;
  assign w_ny_fall  = {1'b0, r_cur.y} + {7'b0, r_cur.spd};
  assign w_dead     = ({1'b0, w_ny_fall} + LP_PLYR_H12) >= LP_SCR_H12;
  assign w_bounce_y = (i_floor < LP_PLYR_H) ? 10'd0 : i_floor - LP_PLYR_H;

  gravity_divider #(.DIV(GRAV_DIV)) u_grav (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (w_grav_en),
    .i_clr  (w_grav_clr),
    .o_wrap (w_wrap)
  );

  always_comb begin
    w_nxt    = r_cur;
    w_scroll = '0;
    w_bounce = 1'b0;
    if (i_frame_tick) begin
      case (r_cur.st)
        ST_IDLE, ST_DEAD: begin
          if (w_start_ok) begin
            w_nxt.st  = ST_RISE;
            w_nxt.y   = LP_START;
            w_nxt.spd = LP_JUMP;
          end
        end
        ST_RISE: begin
          if (w_ny_rise < LP_SCROLL_S) begin
            w_nxt.y  = LP_SCROLL;
            w_scroll = w_scr_diff[9:0];
          end else begin
            w_nxt.y  = w_ny_rise[9:0];
          end
          // Apex: speed would reach zero, turn around at 1 px/tick.
          if (w_wrap) begin
            if (r_cur.spd <= 4'd1) begin
              w_nxt.st  = ST_FALL;
              w_nxt.spd = 4'd1;
            end else begin
              w_nxt.spd = r_cur.spd - 4'd1;
            end
          end
        end
        ST_FALL: begin
          if (i_hit) begin
            w_nxt.st  = ST_RISE;
            w_nxt.y   = w_bounce_y;
            w_nxt.spd = LP_JUMP;
            w_bounce  = 1'b1;
          end else if (w_dead) begin
            w_nxt.st  = ST_DEAD;
            w_nxt.y   = LP_DEAD_Y;
            w_nxt.spd = 4'd0;
          end else begin
            w_nxt.y = w_ny_fall[9:0];
            if (w_wrap && (r_cur.spd < LP_MAXF)) w_nxt.spd = r_cur.spd + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur.st  <= ST_IDLE;
      r_cur.y   <= LP_START;
      r_cur.spd <= 4'd0;
      r_fly     <= 1'b0;
      r_scroll  <= '0;
      r_bounce  <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_cur    <= w_nxt;
      r_fly    <= (w_nxt.st == ST_RISE);
      r_scroll <= w_scroll;
      r_bounce <= w_bounce;
      if (i_frame_tick)           r_pend <= 1'b0;
      else if (i_start && w_rest) r_pend <= 1'b1;
    end
  end

`ifdef SCROLL_SCORE_EN
  logic [15:0] r_score;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)         r_score <= '0;
    else if (w_start_ok)  r_score <= '0;
    else if (i_frame_tick) r_score <= sat_add16(r_score, w_scroll);
  end

  assign o_score = r_score;
`else
  assign o_score = 16'd0;
`endif

  assign o_plyr_y     = r_cur.y;
  assign o_spd_y      = r_cur.spd;
  assign o_state      = r_cur.st;
  assign o_fly        = r_fly;
  assign o_scroll_amt = r_scroll;
  assign o_bounce     = r_bounce;

endmodule

// File: tb/tb_player_jump_ctrl.sv
// Randomized and directed bench for player_jump_ctrl against an integer
// reference model of the jump physics rules.
module tb_player_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick, start, hit;
  logic [9:0]  floor_y;
  logic [9:0]  o_plyr_y, o_scroll_amt;
  logic [3:0]  o_spd_y;
  logic [1:0]  o_state;
  logic        o_fly, o_bounce;
  logic [15:0] o_score;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mst, my, mspd, mg, mscr, mbnc, mscore, mpend;

  player_jump_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_tick(frame_tick), .i_start(start),
    .i_hit(hit), .i_floor(floor_y), .o_plyr_y(o_plyr_y), .o_spd_y(o_spd_y),
    .o_state(o_state), .o_fly(o_fly), .o_scroll_amt(o_scroll_amt),
    .o_bounce(o_bounce), .o_score(o_score)
  );

  always #5 clk = ~clk;

  wire [43:0] obs = {o_plyr_y, o_spd_y, o_state, o_fly, o_scroll_amt, o_bounce, o_score};

  function automatic logic [43:0] expv();
    logic fly;
    fly = (mst == 1);
    return {10'(my), 4'(mspd), 2'(mst), fly, 10'(mscr), 1'(mbnc), 16'(mscore)};
  endfunction

  task automatic model_reset();
    mst = 0; my = 400; mspd = 0; mg = 0; mscr = 0; mbnc = 0; mscore = 0; mpend = 0;
  endtask

  task automatic model_step(input int t, input int s, input int h, input int f);
    int ny;
    mscr = 0; mbnc = 0;
    if (t != 0) begin
      if (mst == 0 || mst == 3) begin
        if (s != 0 || mpend != 0) begin
          mst = 1; my = 400; mspd = 12; mg = 0; mscore = 0;
        end
      end else if (mst == 1) begin
        ny = my - mspd;
        if (ny < 160) begin mscr = 160 - ny; my = 160; end
        else my = ny;
        mg = mg + 1;
        if (mg == 3) begin
          mg = 0; mspd = mspd - 1;
          if (mspd == 0) begin mst = 2; mspd = 1; end
        end
      end else begin
        if (h != 0) begin
          my = (f < 20) ? 0 : f - 20; mspd = 12; mg = 0; mst = 1; mbnc = 1;
        end else begin
          ny = my + mspd;
          if (ny + 20 >= 480) begin mst = 3; my = 460; mspd = 0; end
          else begin
            my = ny; mg = mg + 1;
            if (mg == 3) begin mg = 0; if (mspd < 10) mspd = mspd + 1; end
          end
        end
      end
`ifdef SCROLL_SCORE_EN
      mscore = (mscore + mscr > 65535) ? 65535 : mscore + mscr;
`endif
      mpend = 0;
    end else if (s != 0 && (mst == 0 || mst == 3)) begin
      mpend = 1;
    end
  endtask

  task automatic drive(input int t, input int s, input int h, input int f);
    frame_tick = 1'(t); start = 1'(s); hit = 1'(h); floor_y = 10'(f);
    @(posedge clk);
    model_step(t, s, h, f);
    #1;
    frame_tick = 1'b0; start = 1'b0; hit = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL reset_vals obs=%h exp=%h", obs, expv()); end
    total++;
    if (o_plyr_y !== 10'd400 || o_state !== 2'd0 || o_fly !== 1'b0) begin
      bad++; $display("FAIL reset_const y=%0d st=%0d fly=%0d exp 400/0/0", o_plyr_y, o_state, o_fly);
    end
  endtask

  task automatic test_start();
    drive(1, 1, 0, 0);
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL start_model obs=%h exp=%h", obs, expv()); end
    total++;
    if (o_state !== 2'd1 || o_plyr_y !== 10'd400 || o_spd_y !== 4'd12 || o_fly !== 1'b1) begin
      bad++; $display("FAIL start_const st=%0d y=%0d spd=%0d fly=%0d exp 1/400/12/1",
                      o_state, o_plyr_y, o_spd_y, o_fly);
    end
  endtask

  task automatic test_rise_to_fall();
    for (int i = 0; i < 36; i++) begin
      drive(1, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
      total++;
      if (obs !== expv() || o_plyr_y < 10'd160) begin
        bad++; $display("FAIL rise_step%0d obs=%h exp=%h", i, obs, expv());
      end
    end
    total++;
    if (o_state !== 2'd2 || o_spd_y !== 4'd1 || o_plyr_y !== 10'd166) begin
      bad++; $display("FAIL apex st=%0d spd=%0d y=%0d exp 2/1/166", o_state, o_spd_y, o_plyr_y);
    end
  endtask

  task automatic test_bounce();
    drive(1, 0, 1, 300);
    total++;
    if (o_plyr_y !== 10'd280 || o_spd_y !== 4'd12 || o_state !== 2'd1 || o_bounce !== 1'b1) begin
      bad++; $display("FAIL bounce y=%0d spd=%0d st=%0d b=%0d exp 280/12/1/1",
                      o_plyr_y, o_spd_y, o_state, o_bounce);
    end
    drive(0, 0, 1, 300);
    total++;
    if (o_bounce !== 1'b0 || obs !== expv()) begin
      bad++; $display("FAIL bounce_pulse obs=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_scroll();
    int n = 0;
    int sc0;
    while (mst != 2 && n < 200) begin
      drive(1, 0, 0, 0); n++;
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL scroll_climb obs=%h exp=%h", obs, expv()); end
    end
    total++;
    if (mst != 2) begin bad++; $display("FAIL scroll_timeout st=%0d exp 2", o_state); end
    drive(1, 0, 1, 185);
    sc0 = int'(o_score);
    drive(1, 0, 0, 0);
    total++;
    if (o_plyr_y !== 10'd160 || o_scroll_amt !== 10'd7) begin
      bad++; $display("FAIL scroll_clamp y=%0d amt=%0d exp 160/7", o_plyr_y, o_scroll_amt);
    end
    total++;
`ifdef SCROLL_SCORE_EN
    if (int'(o_score) != sc0 + 7) begin bad++; $display("FAIL score_add got=%0d exp=%0d", o_score, sc0 + 7); end
`else
    if (o_score !== 16'd0) begin bad++; $display("FAIL score_off got=%0d exp=0", o_score); end
`endif
    drive(0, 0, 0, 0);
    total++;
    if (o_scroll_amt !== 10'd0 || obs !== expv()) begin
      bad++; $display("FAIL scroll_pulse obs=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_death_and_restart();
    int n = 0;
    while (mst != 3 && n < 400) begin
      drive(1, 0, 0, 0); n++;
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL fall_path obs=%h exp=%h", obs, expv()); end
    end
    total++;
    if (o_state !== 2'd3 || o_plyr_y !== 10'd460 || o_spd_y !== 4'd0) begin
      bad++; $display("FAIL death st=%0d y=%0d spd=%0d exp 3/460/0", o_state, o_plyr_y, o_spd_y);
    end
    drive(1, 0, 1, 300);
    drive(0, 1, 0, 0);
    total++;
    if (o_state !== 2'd3) begin bad++; $display("FAIL dead_hold st=%0d exp 3", o_state); end
    drive(1, 0, 0, 0);
    total++;
    if (o_state !== 2'd1 || o_plyr_y !== 10'd400 || obs !== expv()) begin
      bad++; $display("FAIL pend_start obs=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_hit_beats_death();
    int n = 0;
    while (!(mst == 2 && my + mspd + 20 >= 480) && n < 400) begin
      drive(1, 0, 0, 0); n++;
    end
    total++;
    if (obs !== expv() || n >= 400) begin bad++; $display("FAIL edge_reach obs=%h exp=%h", obs, expv()); end
    drive(1, 0, 1, 470);
    total++;
    if (o_state !== 2'd1 || o_plyr_y !== 10'd450 || o_bounce !== 1'b1) begin
      bad++; $display("FAIL hit_wins st=%0d y=%0d b=%0d exp 1/450/1", o_state, o_plyr_y, o_bounce);
    end
  endtask

  task automatic test_floor_underflow();
    int n = 0;
    while (mst != 2 && n < 200) begin drive(1, 0, 0, 0); n++; end
    drive(1, 0, 1, 5);
    total++;
    if (o_plyr_y !== 10'd0 || o_state !== 2'd1) begin
      bad++; $display("FAIL underflow y=%0d st=%0d exp 0/1", o_plyr_y, o_state);
    end
    drive(1, 0, 0, 0);
    total++;
    if (o_plyr_y !== 10'd160 || o_scroll_amt !== 10'd172 || obs !== expv()) begin
      bad++; $display("FAIL neg_scroll y=%0d amt=%0d exp 160/172", o_plyr_y, o_scroll_amt);
    end
  endtask

  task automatic test_random();
    int t, s, h, f;
    for (int i = 0; i < 3000; i++) begin
      t = ($urandom_range(0, 2) != 0) ? 1 : 0;
      s = ($urandom_range(0, 15) == 0) ? 1 : 0;
      h = ($urandom_range(0, 5) == 0) ? 1 : 0;
      f = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 25)) : int'($urandom_range(0, 1023));
      drive(t, s, h, f);
      total++;
      if (obs !== expv()) begin bad++; $display("FAIL rand_%0d obs=%h exp=%h", i, obs, expv()); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    if (mst == 0 || mst == 3) drive(1, 1, 0, 0);
    while (mst != 2 && n < 200) begin drive(1, 0, 0, 0); n++; end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (obs !== expv() || o_state !== 2'd0 || o_plyr_y !== 10'd400) begin
      bad++; $display("FAIL async_rst obs=%h exp=%h", obs, expv());
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 0, 0);
    total++;
    if (obs !== expv()) begin bad++; $display("FAIL post_rst obs=%h exp=%h", obs, expv()); end
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; hit = 1'b0; floor_y = '0;
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_start();
    test_rise_to_fall();
    test_bounce();
    test_scroll();
    test_death_and_restart();
    test_hit_beats_death();
    test_floor_underflow();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
